// File: rtl/sel_mux_tree_reg.sv
// Registered N:1 lane multiplexer built from 4:1 and 2:1 cells.
// out_c is the zero-latency selection and out_q is its one-cycle registered copy.
module sel_mux_tree_reg #(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    valid_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in,
  output logic [WIDTH-1:0]        out_c,
  output logic [WIDTH-1:0]        out_q,
  output logic                    valid_q
);

  // Each tree level consumes two select bits, except a lone 2:1 root level.
  localparam int NLVL    = (SEL_W + 1) / 2;
  localparam int SEL_PAD = 2 * NLVL;

  if (NUM_IN < 2 || NUM_IN > 64 || (NUM_IN & (NUM_IN - 1)) != 0 ||
      SEL_W != $clog2(NUM_IN)) begin : g_bad_cfg
    $error("sel_mux_tree_reg: NUM_IN must be a power of two in 2..64 and SEL_W must stay derived");
  end

  function automatic logic [WIDTH-1:0] mux4(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c,
                                            input logic [WIDTH-1:0] d,
                                            input logic [1:0]       s);
    logic [WIDTH-1:0] r;
    case (s)
      2'd0:    r = a;
      2'd1:    r = b;
      2'd2:    r = c;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] mux2(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             s);
    return s ? b : a;
  endfunction

  logic [SEL_PAD-1:0] sel_x;
  logic [WIDTH-1:0]   node [NUM_IN];

  assign sel_x = SEL_PAD'(sel);

  // p0: combinational tree, reduced in place from the leaves toward node[0]
  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      node[k] = in[k*WIDTH +: WIDTH];
    end
    for (int lv = 0; lv < NLVL; lv++) begin
      if (SEL_W - 2*lv >= 2) begin
        for (int j = 0; j < NUM_IN/4; j++) begin
          if (j < (NUM_IN >> (2*lv + 2))) begin
            node[j] = mux4(node[4*j], node[4*j+1], node[4*j+2], node[4*j+3],
                           sel_x[2*lv +: 2]);
          end
        end
      end else begin
        for (int j = 0; j < NUM_IN/2; j++) begin
          if (j < (NUM_IN >> (2*lv + 1))) begin
            node[j] = mux2(node[2*j], node[2*j+1], sel_x[2*lv]);
          end
        end
      end
    end
    out_c = node[0];
  end

  // p1: capture register; out_q holds while valid_in is low
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (valid_in) begin
      out_q   <= out_c;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sel_mux_tree_reg.sv
// Scoreboard bench for sel_mux_tree_reg: default 8x1 instance plus a 4x4 wide instance.
module tb_sel_mux_tree_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration: WIDTH=1, NUM_IN=8
  logic       rn = 1'b0, vi = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] din = '0;
  logic       oc, oq, vq;

  // wide configuration: WIDTH=4, NUM_IN=4
  logic        rn_w = 1'b0, vi_w = 1'b0;
  logic [1:0]  sel_w = '0;
  logic [15:0] din_w = '0;
  logic [3:0]  oc_w, oq_w;
  logic        vq_w;

  sel_mux_tree_reg #(.WIDTH(1), .NUM_IN(8)) dut (
    .clk(clk), .reset_n(rn), .valid_in(vi), .sel(sel), .in(din),
    .out_c(oc), .out_q(oq), .valid_q(vq)
  );

  sel_mux_tree_reg #(.WIDTH(4), .NUM_IN(4)) dut_w (
    .clk(clk), .reset_n(rn_w), .valid_in(vi_w), .sel(sel_w), .in(din_w),
    .out_c(oc_w), .out_q(oq_w), .valid_q(vq_w)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic       q   [$];
  logic [3:0] q_w [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one vector at the falling edge; the next rising edge samples it.
  task automatic step(input logic r, input logic v, input logic [2:0] s,
                      input logic [7:0] d, input logic e, input string name);
    @(negedge clk);
    rn = r; vi = v; sel = s; din = d;
    #1;
    check({name, " out_c"}, 16'(oc), 16'(e));
    if (r && v) q.push_back(e);
  endtask

  task automatic chk_reg(input logic eq, input logic ev, input string name);
    @(posedge clk);
    #1;
    check({name, " out_q"}, 16'(oq), 16'(eq));
    check({name, " valid_q"}, 16'(vq), 16'(ev));
  endtask

  task automatic step_w(input logic r, input logic v, input logic [1:0] s,
                        input logic [15:0] d, input logic [3:0] e, input string name);
    @(negedge clk);
    rn_w = r; vi_w = v; sel_w = s; din_w = d;
    #1;
    check({name, " out_c"}, 16'(oc_w), 16'(e));
    if (r && v) q_w.push_back(e);
  endtask

  task automatic chk_reg_w(input logic [3:0] eq, input logic ev, input string name);
    @(posedge clk);
    #1;
    check({name, " out_q"}, 16'(oq_w), 16'(eq));
    check({name, " valid_q"}, 16'(vq_w), 16'(ev));
  endtask

  // Monitors: every presented valid_q pops one expected capture.
  always @(negedge clk) begin
    if (vq === 1'b1) begin
      if (q.size() == 0) check("valid_q with no pending capture", 16'(vq), 16'd0);
      else               check("monitor out_q", 16'(oq), 16'(q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (vq_w === 1'b1) begin
      if (q_w.size() == 0) check("wide valid_q with no pending capture", 16'(vq_w), 16'd0);
      else                 check("wide monitor out_q", 16'(oq_w), 16'(q_w.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] iv;
    logic [7:0]  dd;
    logic [2:0]  ss;
    logic [7:0]  pat;

    // reset holds registers at zero while out_c follows the lanes
    step(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, "reset1");
    chk_reg(1'b0, 1'b0, "reset1");
    step(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, "reset2");
    chk_reg(1'b0, 1'b0, "reset2");
    step(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, "release");
    chk_reg(1'b1, 1'b1, "release");

    // hold: valid_in low keeps out_q, drops valid_q
    step(1'b1, 1'b1, 3'd0, 8'h01, 1'b1, "hold_cap");
    chk_reg(1'b1, 1'b1, "hold_cap");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, "hold");
      chk_reg(1'b1, 1'b0, "hold");
    end

    // spot checks
    step(1'b1, 1'b1, 3'b101, 8'h20, 1'b1, "spot_20");
    step(1'b1, 1'b1, 3'b101, 8'hDF, 1'b0, "spot_DF");

    // top-level 2:1 split between lanes 0-3 and 4-7
    pat = 8'hF0;
    for (int s = 0; s < 8; s++) step(1'b1, 1'b1, 3'(s), pat, (s >= 4), "split_F0");
    pat = 8'h0F;
    for (int s = 0; s < 8; s++) step(1'b1, 1'b1, 3'(s), pat, (s < 4), "split_0F");

    // mid-stream reset discards the in-flight capture
    step(1'b1, 1'b1, 3'd1, 8'h02, 1'b1, "mid_pre");
    step(1'b0, 1'b1, 3'd1, 8'h02, 1'b1, "mid_rst");
    chk_reg(1'b0, 1'b0, "mid_rst");
    step(1'b1, 1'b1, 3'd2, 8'h04, 1'b1, "mid_resume");
    chk_reg(1'b1, 1'b1, "mid_resume");

    // exhaustive {sel,in} sweep
    for (int i = 0; i < 2048; i++) begin
      iv = 11'(i);
      dd = iv[7:0];
      ss = iv[10:8];
      step(1'b1, 1'b1, ss, dd, dd[ss], "sweep");
    end
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, "drain");
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, "drain");

    // wide configuration, in=16'hA5C3
    step_w(1'b0, 1'b0, 2'd0, 16'hA5C3, 4'h3, "wide_reset");
    chk_reg_w(4'h0, 1'b0, "wide_reset");
    step_w(1'b1, 1'b1, 2'd0, 16'hA5C3, 4'h3, "wide_sel0");
    step_w(1'b1, 1'b1, 2'd1, 16'hA5C3, 4'hC, "wide_sel1");
    step_w(1'b1, 1'b1, 2'd2, 16'hA5C3, 4'h5, "wide_sel2");
    step_w(1'b1, 1'b1, 2'd3, 16'hA5C3, 4'hA, "wide_sel3");
    step_w(1'b1, 1'b0, 2'd0, 16'hA5C3, 4'h3, "wide_hold");
    chk_reg_w(4'hA, 1'b0, "wide_hold");
    step_w(1'b1, 1'b0, 2'd0, 16'hA5C3, 4'h3, "wide_drain");

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard empty", 16'(q.size()), 16'd0);
    check("wide scoreboard empty", 16'(q_w.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
